// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch
//  Purpose  : Instruction prefetch stage. Issues sequential word reads to a
//             synchronous memory port, buffers {pc, word} pairs in a small
//             FIFO and hands them to decode over a valid/ready handshake.
//             A redirect flushes buffered and in-flight words and restarts
//             fetch at a new word address.
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst,
  // memory read port
  output logic        mem_re,
  output logic [29:0] memaddr,
  input  logic [31:0] rmemdata,
  // decode handshake
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [29:0] inst_pc,
  input  logic        inst_ready,
  // fetch redirect
  input  logic        redirect,
  input  logic [29:0] redirect_pc
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0] c_depth = (c_aw+1)'(DEPTH);

  // Fetch-side state
  logic [29:0]     r_fetch_pc;
  logic            r_inflight;
  logic [29:0]     r_inflight_pc;

  // FIFO state
  logic [29:0]     r_pc_q   [DEPTH];
  logic [31:0]     r_data_q [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;

  logic [c_aw:0]   w_occ;
  logic            w_push;
  logic            w_pop;

  // Credit check: entries held plus the word already on its way back.
  // A pop in the same cycle is deliberately not credited so that the
  // request path does not depend on inst_ready.
  always_comb begin
    w_occ      = r_count + (c_aw+1)'(r_inflight);
    mem_re     = !rst && !redirect && (w_occ < c_depth);
    memaddr    = r_fetch_pc;
    inst_valid = (r_count != '0);
    inst       = r_data_q[r_rd_ptr];
    inst_pc    = r_pc_q[r_rd_ptr];
    w_push     = r_inflight && !rst && !redirect;
    w_pop      = inst_valid && inst_ready && !rst && !redirect;
  end

  // Fetch pointer, in-flight tracking and FIFO bookkeeping; redirect flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (redirect) begin
      r_fetch_pc    <= redirect_pc;
      r_inflight    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_inflight <= mem_re;
      if (mem_re) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 30'd1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      r_count <= r_count + (c_aw+1)'(w_push) - (c_aw+1)'(w_pop);
    end
  end

  // FIFO storage: capture the returning word with the address it was fetched from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]   <= r_inflight_pc;
      r_data_q[r_wr_ptr] <= rmemdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch
//  Purpose  : Scoreboard bench for ifetch. Stimulus pushes the expected
//             delivered pc sequence; a monitor pops and compares on every
//             decode handshake. A second instance with RESET_PC near the top
//             of the address space checks fetch address wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_re;
  logic [29:0] memaddr;
  logic [31:0] rmemdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [29:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [29:0] redirect_pc = 30'h0;

  logic        w_mem_re;
  logic [29:0] w_memaddr;
  logic [31:0] w_rmemdata;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [29:0] w_inst_pc;
  logic        w_inst_ready = 1'b1;
  logic        w_redirect = 1'b0;
  logic [29:0] w_redirect_pc = 30'h0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [29:0] exp_q [$];

  always #5 clk = ~clk;

  ifetch #(.DEPTH(4), .RESET_PC(30'h0)) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .memaddr(memaddr),
    .rmemdata(rmemdata), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  ifetch #(.DEPTH(4), .RESET_PC(30'h3FFFFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .mem_re(w_mem_re), .memaddr(w_memaddr),
    .rmemdata(w_rmemdata), .inst_valid(w_inst_valid), .inst(w_inst),
    .inst_pc(w_inst_pc), .inst_ready(w_inst_ready), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc)
  );

  // Synchronous memory models: word at address a is 32'h1000_0000 + a,
  // idle cycles return a junk pattern that must never be captured.
  always @(posedge clk) begin
    rmemdata   <= mem_re   ? (32'h1000_0000 + {2'b00, memaddr})   : 32'hDEAD_BEEF;
    w_rmemdata <= w_mem_re ? (32'h1000_0000 + {2'b00, w_memaddr}) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [29:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 30'(i));
  endtask

  // Hold inst_ready (fixed or random) until every expected word is delivered.
  task automatic drain(input bit rnd);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      inst_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      budget++;
    end
    inst_ready = 1'b0;
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor for the main instance.
  initial begin
    logic [29:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        check("count_le_depth", 64'(dut.r_count <= 3'd4), 64'd1);
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc %0h, expected no delivery", inst_pc);
          end else begin
            e = exp_q.pop_front();
            check("pop_pc", 64'(inst_pc), 64'(e));
            check("pop_inst", 64'(inst), 64'(32'h1000_0000 + {2'b00, e}));
          end
        end
        // A handshake in a redirect cycle is accepted, then everything is flushed.
        if (redirect) exp_q.delete();
      end
    end
  end

  // Monitor for the wrap instance: first four deliveries after each reset.
  initial begin
    logic [29:0] wexp [4];
    int wcnt;
    wexp[0] = 30'h3FFFFFFE;
    wexp[1] = 30'h3FFFFFFF;
    wexp[2] = 30'h0;
    wexp[3] = 30'h1;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wcnt = 0;
      end else if (w_inst_valid && w_inst_ready && wcnt < 4) begin
        check("wrap_pc", 64'(w_inst_pc), 64'(wexp[wcnt]));
        check("wrap_inst", 64'(w_inst), 64'(32'h1000_0000 + {2'b00, wexp[wcnt]}));
        wcnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int          n_issue;
    logic [29:0] issued [8];

    // --- Reset state and sustained streaming with inst_ready high ---
    repeat (3) tick();
    @(negedge clk);
    check("rst_mem_re", 64'(mem_re), 64'd0);
    check("rst_memaddr", 64'(memaddr), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    tick();
    rst = 1'b0;
    inst_ready = 1'b1;
    push_range(30'h0, 20);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("c0_mem_re", 64'(mem_re), 64'd1);
        check("c0_memaddr", 64'(memaddr), 64'd0);
      end
      check("stream_valid", 64'(inst_valid), 64'(c >= 2));
      tick();
    end
    inst_ready = 1'b0;
    check("t1_left", 64'(exp_q.size()), 64'd0);

    // --- Back-pressure from reset: FIFO fills to exactly DEPTH ---
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_issue = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_re) begin
        if (n_issue < 8) issued[n_issue] = memaddr;
        n_issue++;
      end
      tick();
    end
    check("bp_issues", 64'(n_issue), 64'd4);
    for (int i = 0; i < 4; i++) check("bp_addr", 64'(issued[i]), 64'(i));
    @(negedge clk);
    check("bp_count", 64'(dut.r_count), 64'd4);
    check("bp_mem_re", 64'(mem_re), 64'd0);
    tick();
    push_range(30'h0, 12);
    drain(1'b0);

    // --- Redirect in cycle 5 with partial FIFO and a request in flight ---
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_range(30'h0, 3);
    repeat (3) tick();
    inst_ready = 1'b1;
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 30'h40;
    @(negedge clk);
    check("rd_mem_re", 64'(mem_re), 64'd0);
    tick();
    redirect = 1'b0;
    inst_ready = 1'b0;
    push_range(30'h40, 6);
    @(negedge clk);
    check("rd_next_re", 64'(mem_re), 64'd1);
    check("rd_next_addr", 64'(memaddr), 64'h40);
    check("rd_valid_r1", 64'(inst_valid), 64'd0);
    tick();
    @(negedge clk);
    check("rd_valid_r2", 64'(inst_valid), 64'd0);
    tick();
    @(negedge clk);
    check("rd_valid_r3", 64'(inst_valid), 64'd1);
    check("rd_head_pc", 64'(inst_pc), 64'h40);
    tick();
    drain(1'b0);

    // --- Back-to-back redirects, random inst_ready afterwards ---
    tick();
    redirect = 1'b1;
    redirect_pc = 30'h10;
    @(negedge clk);
    check("rr1_mem_re", 64'(mem_re), 64'd0);
    tick();
    redirect_pc = 30'h20;
    @(negedge clk);
    check("rr2_mem_re", 64'(mem_re), 64'd0);
    tick();
    redirect = 1'b0;
    push_range(30'h20, 8);
    @(negedge clk);
    check("rr_next_re", 64'(mem_re), 64'd1);
    check("rr_next_addr", 64'(memaddr), 64'h20);
    tick();
    drain(1'b1);

    // --- One-cycle reset mid-stream with a full FIFO ---
    repeat (8) tick();
    @(negedge clk);
    check("full_count", 64'(dut.r_count), 64'd4);
    check("full_valid", 64'(inst_valid), 64'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mrst_mem_re", 64'(mem_re), 64'd0);
    tick();
    rst = 1'b0;
    push_range(30'h0, 4);
    @(negedge clk);
    check("mrst_valid_c0", 64'(inst_valid), 64'd0);
    check("mrst_re_c0", 64'(mem_re), 64'd1);
    check("mrst_addr_c0", 64'(memaddr), 64'd0);
    tick();
    @(negedge clk);
    check("mrst_valid_c1", 64'(inst_valid), 64'd0);
    tick();
    @(negedge clk);
    check("mrst_valid_c2", 64'(inst_valid), 64'd1);
    check("mrst_pc_c2", 64'(inst_pc), 64'd0);
    tick();
    drain(1'b0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
